// File: rtl/seq_tuple_a_fifo.sv
// seq_tuple_a_fifo
//   Circular-buffer FIFO for the 8-bit `a` field of the upstream register/mux stage.
//   The output is first-word-fall-through: the head entry sits on O_a whenever the FIFO is
//   not empty. Occupancy and full/empty status are exported.
//   The FIFO decouples the always-driven producer from a consumer that may stall.
//
// Ports
//   CLK      clock; all state changes on its rising edge
//   RESETN   synchronous, active-low reset
//   I_a      write data from the upstream stage
//   I_valid  upstream offers I_a this cycle
//   I_ready  FIFO can accept I_a this cycle (= !full)
//   O_a      head-of-FIFO data, 0 when empty
//   O_valid  O_a holds a valid entry (= !empty)
//   O_ready  downstream takes O_a this cycle
//   count    current occupancy, 0..DEPTH
//   full     count == DEPTH
//   empty    count == 0
module seq_tuple_a_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic [WIDTH-1:0]           I_a,
  input  logic                       I_valid,
  output logic                       I_ready,
  output logic [WIDTH-1:0]           O_a,
  output logic                       O_valid,
  input  logic                       O_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic push, pop;

  // Status comes from registered state only. This keeps O_ready out of the I_ready path,
  // so a pop while full does not open the input until the next cycle.
  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    I_ready = ~full;
    O_valid = ~empty;
    count   = count_q;
    O_a     = empty ? '0 : mem_q[rd_ptr_q];
  end

  assign push = I_valid & I_ready;
  assign pop  = O_valid & O_ready;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not cleared on reset. A write during reset is blocked so that a discarded
  // push leaves no trace in the array.
  always_ff @(posedge CLK) begin
    if (RESETN && push) begin
      mem_q[wr_ptr_q] <= I_a;
    end
  end

endmodule

// File: tb/tb_seq_tuple_a_fifo.sv
module tb_seq_tuple_a_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic [W-1:0] I_a = '0;
  logic         I_valid = 1'b0;
  logic         I_ready;
  logic [W-1:0] O_a;
  logic         O_valid;
  logic         O_ready = 1'b0;
  logic [2:0]   count;
  logic         full;
  logic         empty;

  int n_checks = 0;
  int n_errors = 0;

  seq_tuple_a_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .I_a    (I_a),
    .I_valid(I_valid),
    .I_ready(I_ready),
    .O_a    (O_a),
    .O_valid(O_valid),
    .O_ready(O_ready),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs applied before a rising edge, outputs expected just after it.
  typedef struct {
    logic       rstn;
    logic       v;
    logic [7:0] a;
    logic       ordy;
    int         cnt;
    logic       ov;
    logic [7:0] oa;
    logic       ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rstn, logic v, logic [7:0] a, logic ordy,
                              int cnt, logic ov, logic [7:0] oa, logic ir);
    vec_t r;
    r.rstn = rstn; r.v = v; r.a = a; r.ordy = ordy;
    r.cnt = cnt; r.ov = ov; r.oa = oa; r.ir = ir;
    return r;
  endfunction

  task automatic check_outs(input string tag, input int cnt, input logic ov,
                            input logic [7:0] oa, input logic ir);
    chk({tag, " count"},   32'(count),   32'(cnt));
    chk({tag, " O_valid"}, 32'(O_valid), 32'(ov));
    chk({tag, " O_a"},     32'(O_a),     32'(oa));
    chk({tag, " I_ready"}, 32'(I_ready), 32'(ir));
    chk({tag, " full"},    32'(full),    32'(cnt == D));
    chk({tag, " empty"},   32'(empty),   32'(cnt == 0));
  endtask

  logic [7:0] model_q[$];
  logic [7:0] got[$];

  initial begin
    // T1 reset
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
    // T2 fill, dropped 5th word, drain, pop on empty ignored
    vecs.push_back(mk(1, 1, 8'h11, 0, 1, 1, 8'h11, 1));
    vecs.push_back(mk(1, 1, 8'h22, 0, 2, 1, 8'h11, 1));
    vecs.push_back(mk(1, 1, 8'h33, 0, 3, 1, 8'h11, 1));
    vecs.push_back(mk(1, 1, 8'h44, 0, 4, 1, 8'h11, 0));
    vecs.push_back(mk(1, 1, 8'h55, 0, 4, 1, 8'h11, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 3, 1, 8'h22, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 2, 1, 8'h33, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 1, 1, 8'h44, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1));
    // T3 one-cycle latency, no bypass
    vecs.push_back(mk(1, 1, 8'hA5, 0, 1, 1, 8'hA5, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1));
    // T4 simultaneous push and pop
    vecs.push_back(mk(1, 1, 8'h01, 0, 1, 1, 8'h01, 1));
    vecs.push_back(mk(1, 1, 8'h02, 0, 2, 1, 8'h01, 1));
    vecs.push_back(mk(1, 1, 8'h03, 1, 2, 1, 8'h02, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 1, 1, 8'h03, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1));
    // T6 reset mid-operation with push and pop requested
    vecs.push_back(mk(1, 1, 8'h07, 0, 1, 1, 8'h07, 1));
    vecs.push_back(mk(1, 1, 8'h08, 0, 2, 1, 8'h07, 1));
    vecs.push_back(mk(1, 1, 8'h09, 0, 3, 1, 8'h07, 1));
    vecs.push_back(mk(0, 1, 8'h0A, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 1));
    // Full with pop: only the pop happens, I_ready returns next cycle
    vecs.push_back(mk(1, 1, 8'hB1, 0, 1, 1, 8'hB1, 1));
    vecs.push_back(mk(1, 1, 8'hB2, 0, 2, 1, 8'hB1, 1));
    vecs.push_back(mk(1, 1, 8'hB3, 0, 3, 1, 8'hB1, 1));
    vecs.push_back(mk(1, 1, 8'hB4, 0, 4, 1, 8'hB1, 0));
    vecs.push_back(mk(1, 1, 8'hB5, 1, 3, 1, 8'hB2, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 2, 1, 8'hB3, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 1, 1, 8'hB4, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1));

    foreach (vecs[i]) begin
      RESETN  = vecs[i].rstn;
      I_valid = vecs[i].v;
      I_a     = vecs[i].a;
      O_ready = vecs[i].ordy;
      @(posedge CLK);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].oa, vecs[i].ir);
    end

    // T5: stream 0..9 with O_ready toggling 1,0,1,0
    begin
      int idx = 0;
      logic tog = 1'b1;
      int cyc = 0;
      RESETN = 1'b0; I_valid = 1'b0; O_ready = 1'b0;
      @(posedge CLK); #1;
      RESETN = 1'b1;
      got.delete();
      while (got.size() < 10 && cyc < 200) begin
        logic acc;
        I_valid = (idx < 10);
        I_a     = 8'(idx);
        O_ready = tog;
        if (O_valid && O_ready) got.push_back(O_a);
        acc = I_valid && I_ready;
        @(posedge CLK); #1;
        if (acc) idx++;
        tog = ~tog;
        cyc++;
      end
      chk("wrap words received", 32'(got.size()), 32'd10);
      for (int k = 0; k < got.size(); k++) begin
        chk($sformatf("wrap order %0d", k), 32'(got[k]), 32'(k));
      end
      I_valid = 1'b0; O_ready = 1'b1;
      @(posedge CLK); #1;
      chk("wrap drained empty", 32'(empty), 32'd1);
    end

    // Randomized traffic against a queue model
    RESETN = 1'b0; I_valid = 1'b0; O_ready = 1'b0;
    @(posedge CLK); #1;
    RESETN = 1'b1;
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      logic mpush, mpop;
      logic [7:0] va;
      I_valid = ($urandom_range(0, 3) != 0);
      I_a     = 8'($urandom);
      O_ready = ($urandom_range(0, 2) != 0);
      va      = I_a;
      mpush   = I_valid && (model_q.size() < D);
      mpop    = O_ready && (model_q.size() > 0);
      @(posedge CLK); #1;
      if (mpop) void'(model_q.pop_front());
      if (mpush) model_q.push_back(va);
      check_outs($sformatf("rand%0d", c), model_q.size(), model_q.size() > 0,
                 (model_q.size() > 0) ? model_q[0] : 8'h00, model_q.size() < D);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
